// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter: shares one downstream memory port between the IF
// (read-only) and MEM (read/write) pipeline interfaces.
// A three-state FSM serialises the requesters. The granted request is
// captured into the pmem_* registers, and the completion handshake is
// routed back only to the granted requester.
// Optional build macro ARB_ROUND_ROBIN_EN: when it is defined, contention is
// resolved by alternating the grant. When it is undefined, MEM always wins
// over IF.
module lc3b_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] if_memaddr,
  input  logic                  if_memread,
  input  logic [1:0]            if_mem_byte_enable,
  output logic                  if_mem_resp,
  output logic [DATA_WIDTH-1:0] if_mem_rdata,
  input  logic [ADDR_WIDTH-1:0] mem_memaddr,
  input  logic                  mem_memread,
  input  logic                  mem_memwrite,
  input  logic [DATA_WIDTH-1:0] mem_mem_wdata,
  input  logic [1:0]            mem_mem_byte_enable,
  output logic                  mem_mem_resp,
  output logic [DATA_WIDTH-1:0] mem_mem_rdata,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [DATA_WIDTH-1:0] pmem_wdata,
  output logic [1:0]            pmem_byte_enable,
  input  logic                  pmem_resp,
  input  logic [DATA_WIDTH-1:0] pmem_rdata,
  output logic                  arb_busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_IF  = 2'd1,
    SERVE_MEM = 2'd2
  } state_t;

  state_t state;
  logic   mem_req;
  logic   grant_mem;

  assign mem_req = mem_memread | mem_memwrite;

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant: 1'b1 means MEM was served last, 1'b0 means IF
  logic last_grant;

  // Under contention, grant whichever requester was not served last
  always_comb begin
    grant_mem = 1'b0;
    if (mem_req && if_memread) begin
      grant_mem = ~last_grant;
    end else begin
      grant_mem = mem_req;
    end
  end

  // Remember the most recent grant, updated on every entry to a SERVE state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b0;
    end else if (state == IDLE && (mem_req || if_memread)) begin
      last_grant <= grant_mem;
    end else begin
      last_grant <= last_grant;
    end
  end
`else
  // Fixed priority: any MEM request wins over IF
  always_comb begin
    grant_mem = 1'b0;
    if (mem_req) begin
      grant_mem = 1'b1;
    end else begin
      grant_mem = 1'b0;
    end
  end
`endif

  // Arbitration FSM; captures the granted request into the pmem_* registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      pmem_address     <= {ADDR_WIDTH{1'b0}};
      pmem_wdata       <= {DATA_WIDTH{1'b0}};
      pmem_byte_enable <= 2'b00;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_mem) begin
            state            <= SERVE_MEM;
            pmem_address     <= mem_memaddr;
            pmem_wdata       <= mem_mem_wdata;
            pmem_byte_enable <= mem_mem_byte_enable;
            // A simultaneous read and write is illegal; the write wins
            pmem_write       <= mem_memwrite;
            pmem_read        <= mem_memread & ~mem_memwrite;
          end else if (if_memread) begin
            state            <= SERVE_IF;
            pmem_address     <= if_memaddr;
            pmem_wdata       <= {DATA_WIDTH{1'b0}};
            pmem_byte_enable <= if_mem_byte_enable;
            pmem_read        <= 1'b1;
            pmem_write       <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        SERVE_IF, SERVE_MEM: begin
          // Hold the captured request until the downstream completes
          if (pmem_resp) begin
            state      <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end else begin
            state <= state;
          end
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  // Route the completion strobe and read data to the granted requester only
  always_comb begin
    if_mem_resp   = 1'b0;
    mem_mem_resp  = 1'b0;
    if_mem_rdata  = {DATA_WIDTH{1'b0}};
    mem_mem_rdata = {DATA_WIDTH{1'b0}};
    if (state == SERVE_IF && pmem_resp) begin
      if_mem_resp  = 1'b1;
      if_mem_rdata = pmem_rdata;
    end else if (state == SERVE_MEM && pmem_resp) begin
      mem_mem_resp  = 1'b1;
      mem_mem_rdata = pmem_rdata;
    end else begin
      if_mem_resp  = 1'b0;
      mem_mem_resp = 1'b0;
    end
  end

  assign arb_busy = (state != IDLE);

endmodule
